// File: rtl/kmeans_update_writer_if.sv
// Cacheline streams around the k-means update writer: the operator-side input
// stream (no backpressure) and the write-engine-side output stream (valid/ready).
interface kmeans_update_writer_if;
  // Output handshake: a line transfers on a rising edge where wr_cl_valid and
  // wr_cl_ready are both high. While valid is high and ready is low, wr_cl and
  // wr_cl_last hold steady. Valid never waits on ready. The input strobe has no
  // ready: the source must treat every updated_centroid_valid cycle as consumed.
  logic [511:0] updated_centroid;
  logic         updated_centroid_valid;
  logic         updated_centroid_last;
  logic [511:0] wr_cl;
  logic         wr_cl_valid;
  logic         wr_cl_last;
  logic         wr_cl_ready;

  // master: the writer block; slave: operator plus write engine around it
  modport master (
    input  updated_centroid, updated_centroid_valid, updated_centroid_last,
    input  wr_cl_ready,
    output wr_cl, wr_cl_valid, wr_cl_last
  );

  modport slave (
    output updated_centroid, updated_centroid_valid, updated_centroid_last,
    output wr_cl_ready,
    input  wr_cl, wr_cl_valid, wr_cl_last
  );
endinterface

// File: rtl/kmeans_update_writer.sv
// Elastic FIFO between the k-means operator and the write engine; counts drained
// iterations, raises um_done at the configured limit, and tracks dropped lines.
module kmeans_update_writer #(
  parameter int FIFO_DEPTH      = 64,
  parameter int FIFO_DEPTH_BITS = 6,
  parameter int ITER_BITS       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_operator,
  input  logic [ITER_BITS-1:0]      max_iteration,
  kmeans_update_writer_if.master    bus,
  output logic                      um_done,
  output logic [ITER_BITS-1:0]      iteration_cnt,
  output logic                      overflow,
  output logic [FIFO_DEPTH_BITS:0]  fill_level,
  output logic [3:0][31:0]          debug_cnt,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [FIFO_DEPTH_BITS:0] DEPTH_L = (FIFO_DEPTH_BITS+1)'(FIFO_DEPTH);

  state_t                     state;
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   count;
  logic [ITER_BITS-1:0]       limit_q;
  logic [512:0]               mem [FIFO_DEPTH];

  logic [512:0]         head;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic                 iter_inc;
  logic [ITER_BITS-1:0] iter_next;

  // Bit 512 of each entry carries the last marker alongside the 512-bit line
  assign head        = mem[rd_ptr];
  assign bus.wr_cl_valid = (count != '0);
  assign bus.wr_cl       = bus.wr_cl_valid ? head[511:0] : '0;
  assign bus.wr_cl_last  = bus.wr_cl_valid & head[512];

  assign pop  = bus.wr_cl_valid & bus.wr_cl_ready;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign push = (state == RUN) & bus.updated_centroid_valid & ((count != DEPTH_L) | pop);
  assign drop = bus.updated_centroid_valid &
                (((state == RUN) & ~push) | (state == DONE));

  assign iter_inc  = pop & head[512];
  assign iter_next = (iteration_cnt == '1) ? iteration_cnt : iteration_cnt + 1'b1;

  assign fill_level = count;
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (push && !start_operator && !rst) begin
      mem[wr_ptr] <= {bus.updated_centroid_last, bus.updated_centroid};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      limit_q       <= '0;
      um_done       <= 1'b0;
      iteration_cnt <= '0;
      overflow      <= 1'b0;
      debug_cnt     <= '0;
    end else if (start_operator) begin
      // Flush wins over any coincident push or pop
      state         <= RUN;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      limit_q       <= (max_iteration == '0) ? ITER_BITS'(1) : max_iteration;
      um_done       <= 1'b0;
      iteration_cnt <= '0;
      overflow      <= 1'b0;
      debug_cnt     <= '0;
    end else begin
      if (push) begin
        wr_ptr       <= wr_ptr + 1'b1;
        debug_cnt[0] <= debug_cnt[0] + 32'd1;
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        debug_cnt[1] <= debug_cnt[1] + 32'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (drop) begin
        debug_cnt[2] <= debug_cnt[2] + 32'd1;
        if (state == RUN) overflow <= 1'b1;
      end

      if (iter_inc) begin
        iteration_cnt <= iter_next;
        debug_cnt[3]  <= debug_cnt[3] + 32'd1;
        if (state == RUN && iter_next == limit_q) begin
          state   <= DONE;
          um_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_kmeans_update_writer.sv
// Directed bench for kmeans_update_writer: drivers push expected lines into a
// scoreboard queue, a negedge monitor checks every output handshake against it.
module tb_kmeans_update_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_operator;
  logic [15:0] max_iteration;
  logic        um_done;
  logic [15:0] iteration_cnt;
  logic        overflow;
  logic [6:0]  fill_level;
  logic [3:0][31:0] debug_cnt;
  logic [1:0]  state_dbg;

  kmeans_update_writer_if bus();

  kmeans_update_writer #(
    .FIFO_DEPTH(64), .FIFO_DEPTH_BITS(6), .ITER_BITS(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_operator (start_operator),
    .max_iteration  (max_iteration),
    .bus            (bus),
    .um_done        (um_done),
    .iteration_cnt  (iteration_cnt),
    .overflow       (overflow),
    .fill_level     (fill_level),
    .debug_cnt      (debug_cnt),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [512:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;
  int seq       = 0;

  function automatic logic [511:0] pat(input int id);
    logic [31:0] w;
    w = 32'(id) ^ 32'h5A5A_0000;
    return {16{w}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.wr_cl_valid && bus.wr_cl_ready) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_line: got %0h expected none", {bus.wr_cl_last, bus.wr_cl[31:0]});
      end else begin
        logic [512:0] e;
        e = exp_q.pop_front();
        if ({bus.wr_cl_last, bus.wr_cl} === e) pass_cnt++;
        else $display("FAIL line_data: got last=%0b w0=%0h expected last=%0b w0=%0h",
                      bus.wr_cl_last, bus.wr_cl[31:0], e[512], e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(input logic [15:0] max_it);
    start_operator = 1'b1;
    max_iteration  = max_it;
    tick(1);
    start_operator = 1'b0;
  endtask

  task automatic push_line(input logic last, input bit expect_out);
    bus.updated_centroid       = pat(seq);
    bus.updated_centroid_last  = last;
    bus.updated_centroid_valid = 1'b1;
    if (expect_out) exp_q.push_back({last, pat(seq)});
    seq++;
    tick(1);
    bus.updated_centroid_valid = 1'b0;
    bus.updated_centroid_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      tick(1);
      i++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},    64'(bus.wr_cl_valid), 64'd0);
    check({tag, "_last"},     64'(bus.wr_cl_last),  64'd0);
    check({tag, "_wr_cl"},    64'(|bus.wr_cl),      64'd0);
    check({tag, "_um_done"},  64'(um_done),         64'd0);
    check({tag, "_iter"},     64'(iteration_cnt),   64'd0);
    check({tag, "_overflow"}, 64'(overflow),        64'd0);
    check({tag, "_fill"},     64'(fill_level),      64'd0);
    check({tag, "_dbg"},      64'(|debug_cnt),      64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    rst = 1'b1;
    start_operator = 1'b0;
    max_iteration  = '0;
    bus.updated_centroid       = '0;
    bus.updated_centroid_valid = 1'b0;
    bus.updated_centroid_last  = 1'b0;
    bus.wr_cl_ready            = 1'b0;
    tick(3);
    check_reset_outputs("por");
    rst = 1'b0;

    // IDLE strobes are ignored
    push_line(1'b0, 1'b0);
    push_line(1'b1, 1'b0);
    check("idle_fill", 64'(fill_level), 64'd0);
    check("idle_dbg",  64'(|debug_cnt), 64'd0);

    // Basic: two iterations of three lines, ready held high
    bus.wr_cl_ready = 1'b1;
    start_run(16'd2);
    for (int k = 0; k < 6; k++) push_line((k == 2) || (k == 5), 1'b1);
    check("basic_done_early", 64'(um_done),       64'd0);
    check("basic_iter_mid",   64'(iteration_cnt), 64'd1);
    tick(1);
    check("basic_um_done",    64'(um_done),       64'd1);
    check("basic_iter",       64'(iteration_cnt), 64'd2);
    check("basic_dbg0",       64'(debug_cnt[0]),  64'd6);
    check("basic_dbg1",       64'(debug_cnt[1]),  64'd6);
    check("basic_dbg2",       64'(debug_cnt[2]),  64'd0);
    check("basic_dbg3",       64'(debug_cnt[3]),  64'd2);
    check("basic_q_empty",    64'(exp_q.size()),  64'd0);

    // max_iteration = 0 behaves as one iteration; DONE drops count without overflow
    start_run(16'd0);
    push_line(1'b1, 1'b1);
    tick(1);
    check("zero_um_done", 64'(um_done),       64'd1);
    check("zero_iter",    64'(iteration_cnt), 64'd1);
    push_line(1'b0, 1'b0);
    push_line(1'b1, 1'b0);
    check("done_drop_cnt",  64'(debug_cnt[2]), 64'd2);
    check("done_overflow",  64'(overflow),     64'd0);
    check("done_fill",      64'(fill_level),   64'd0);
    check("done_iter_hold", 64'(iteration_cnt), 64'd1);

    // Backpressure: fill to 64, 65th line overflows, then drain intact
    bus.wr_cl_ready = 1'b0;
    start_run(16'd1);
    for (int k = 0; k < 64; k++) push_line(k == 63, 1'b1);
    check("bp_fill_full", 64'(fill_level),   64'd64);
    check("bp_no_ovf",    64'(overflow),     64'd0);
    check("bp_hold_last", 64'(bus.wr_cl_last), 64'd0);
    push_line(1'b0, 1'b0);
    check("bp_ovf",       64'(overflow),     64'd1);
    check("bp_drop",      64'(debug_cnt[2]), 64'd1);
    check("bp_fill_keep", 64'(fill_level),   64'd64);
    check("bp_accepted",  64'(debug_cnt[0]), 64'd64);
    bus.wr_cl_ready = 1'b1;
    wait_drain("bp_drain", 100);
    check("bp_fill_empty", 64'(fill_level),   64'd0);
    check("bp_drained",    64'(debug_cnt[1]), 64'd64);
    check("bp_um_done",    64'(um_done),      64'd1);

    // Full boundary: full FIFO, push and pop every cycle for 100 cycles
    bus.wr_cl_ready = 1'b0;
    start_run(16'd1000);
    for (int k = 0; k < 64; k++) push_line(1'b0, 1'b1);
    check("full_fill", 64'(fill_level), 64'd64);
    bus.wr_cl_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      push_line(1'b0, 1'b1);
      if (fill_level != 7'd64) bad++;
    end
    check("full_fill_steady", 64'(bad),          64'd0);
    check("full_no_ovf",      64'(overflow),     64'd0);
    check("full_no_drop",     64'(debug_cnt[2]), 64'd0);
    check("full_accepted",    64'(debug_cnt[0]), 64'd164);
    wait_drain("full_drain", 100);
    check("full_drained",     64'(debug_cnt[1]), 64'd164);

    // Restart with 10 lines buffered; coincident push is discarded
    bus.wr_cl_ready = 1'b0;
    start_run(16'd1);
    for (int k = 0; k < 10; k++) push_line(1'b0, 1'b1);
    check("rs_fill10", 64'(fill_level), 64'd10);
    start_operator = 1'b1;
    max_iteration  = 16'd1;
    bus.updated_centroid       = pat(seq);
    bus.updated_centroid_valid = 1'b1;
    seq++;
    tick(1);
    start_operator = 1'b0;
    bus.updated_centroid_valid = 1'b0;
    exp_q.delete();
    check("rs_fill0",  64'(fill_level),      64'd0);
    check("rs_valid",  64'(bus.wr_cl_valid), 64'd0);
    check("rs_dbg",    64'(|debug_cnt),      64'd0);
    check("rs_iter",   64'(iteration_cnt),   64'd0);
    check("rs_ovf",    64'(overflow),        64'd0);
    bus.wr_cl_ready = 1'b1;
    push_line(1'b0, 1'b1);
    push_line(1'b1, 1'b1);
    wait_drain("rs_drain", 10);
    check("rs_um_done", 64'(um_done),       64'd1);
    check("rs_iter1",   64'(iteration_cnt), 64'd1);
    check("rs_dbg0",    64'(debug_cnt[0]),  64'd2);
    check("rs_dbg3",    64'(debug_cnt[3]),  64'd1);

    // Reset mid-run while output is valid
    bus.wr_cl_ready = 1'b0;
    start_run(16'd3);
    for (int k = 0; k < 5; k++) push_line(k == 4, 1'b1);
    check("rst_pre_valid", 64'(bus.wr_cl_valid), 64'd1);
    rst = 1'b1;
    tick(1);
    exp_q.delete();
    check_reset_outputs("midrst");
    rst = 1'b0;
    bus.wr_cl_ready = 1'b1;
    push_line(1'b1, 1'b0);
    push_line(1'b0, 1'b0);
    tick(1);
    check("post_rst_fill",  64'(fill_level),      64'd0);
    check("post_rst_valid", 64'(bus.wr_cl_valid), 64'd0);
    check("post_rst_dbg",   64'(|debug_cnt),      64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/kmeans_update_writer.md
# kmeans_update_writer

Elastic output stage placed directly downstream of the k-means operator: absorbs the 512-bit updated-centroid cachelines (the operator has no backpressure), and presents them to the write engine over a valid/ready handshake. Counts completed k-means iterations from the drained `last` markers and raises `um_done` once the configured iteration count has been written back. Also flags and counts any cachelines lost to overflow.

## Interface
Parameters:
- FIFO_DEPTH, 64, cacheline entries buffered; power of two, ≥ 2
- FIFO_DEPTH_BITS, 6, log2(FIFO_DEPTH)
- ITER_BITS, 16, width of iteration limit/counter

Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start_operator  in  1  one-cycle pulse: begin a run
- max_iteration  in  ITER_BITS  iterations to write back; sampled on start_operator; 0 treated as 1
- updated_centroid  in  512  centroid cacheline from operator
- updated_centroid_valid  in  1  cacheline strobe, no backpressure
- updated_centroid_last  in  1  last cacheline of one iteration's update set
- wr_cl  out  512  cacheline to write engine
- wr_cl_valid  out  1  wr_cl holds data
- wr_cl_last  out  1  last marker travelling with wr_cl
- wr_cl_ready  in  1  write engine accepts
- um_done  out  1  level; all iterations drained
- iteration_cnt  out  ITER_BITS  completed iterations
- overflow  out  1  sticky; a cacheline was dropped while RUN
- fill_level  out  FIFO_DEPTH_BITS+1  current FIFO occupancy
- debug_cnt  out  4×32  [0] accepted, [1] drained, [2] dropped, [3] iterations

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- start_operator (any state, highest priority): flush FIFO, clear iteration_cnt, overflow, um_done, debug_cnt; latch max_iteration; → RUN.
- IDLE: input strobes ignored, not counted.
- RUN: push {last, data} when updated_centroid_valid and (count < FIFO_DEPTH or a pop occurs this cycle). Otherwise the line is dropped: overflow ← 1, debug_cnt[2]++.
- Pop on wr_cl_valid & wr_cl_ready. If the popped entry has last=1: iteration_cnt++, debug_cnt[3]++; if the new value equals the latched limit → DONE.
- DONE: um_done=1; input strobes dropped and counted in debug_cnt[2] (overflow unaffected); residual FIFO entries (none in a correct run) still drain.
- wr_cl/wr_cl_last stable while wr_cl_valid & !wr_cl_ready.
- Counters 32-bit wrapping; iteration_cnt saturates at all-ones.

## Timing
- Reset values: wr_cl_valid=0, wr_cl_last=0, wr_cl=0, um_done=0, iteration_cnt=0, overflow=0, fill_level=0, debug_cnt all 0.
- Push-to-output latency: 1 cycle (line pushed in cycle t is visible on wr_cl_valid at t+1 if FIFO was empty).
- Throughput: 1 line/cycle in and out with simultaneous push/pop; fill_level unchanged.
- Full + push + pop same cycle: push accepted, no overflow.
- Empty + push: no same-cycle bypass.
- um_done rises the cycle after the handshake of the final last line; held until start_operator or rst.
- start_operator coincident with push: push discarded (flush wins); coincident with a pop: pop not counted.
- rst mid-run: all state cleared next edge, in-flight lines lost, wr_cl_valid low.
- Pointers wrap modulo FIFO_DEPTH; fill_level reaches exactly FIFO_DEPTH.

## Test plan
- Basic: max_iteration=2, send 3 lines (3rd last) twice, wr_cl_ready=1 → 6 lines out in order, iteration_cnt=2, um_done high 1 cycle after 6th handshake, debug_cnt={6,6,0,2}.
- Backpressure: wr_cl_ready=0, push 64 lines → fill_level=64, overflow=0; 65th push → overflow=1, debug_cnt[2]=1; release ready → 64 lines drain intact.
- Full boundary: FIFO full, ready=1, push every cycle for 100 cycles → no drops, fill_level stays 64.
- max_iteration=0: one iteration (1 last line) → um_done=1, iteration_cnt=1.
- Restart: mid-run with 10 lines buffered, pulse start_operator → fill_level=0, counters zero, wr_cl_valid low next cycle, new run completes normally.
- Reset: assert rst while wr_cl_valid=1 → next cycle all outputs at reset values; IDLE input strobes not counted.
